// File: rtl/song_library.sv
`default_nettype none
// ============================================================================
//  Module   : song_library
//  Purpose  : Song ROM feeding auto_mode. Holds four fixed songs of up to 32
//             entries, returns the registered note/duration of the addressed
//             entry, handles next/prev song selection from button levels,
//             detects end-of-song markers and raises a one-cycle restart
//             pulse used by the top level to rewind auto_mode.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1   system clock (100 MHz)
//    rst             in   1   asynchronous active-low reset
//    memory_location in   5   entry index from auto_mode
//    song_next       in   1   debounced level, rising edge = next song
//    song_prev       in   1   debounced level, rising edge = previous song
//    note_value      out  4   registered note (0 = rest, 1..14 = pitch)
//    duration_value  out  26  registered duration in clk cycles
//    song_index      out  2   currently selected song
//    end_of_song     out  1   high while the fetched entry is an end marker
//    song_restart    out  1   one-cycle pulse on song change / end of song
// ============================================================================
module song_library #(
  parameter logic [25:0] GAP_CYCLES = 26'd25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  memory_location,
  input  logic        song_next,
  input  logic        song_prev,
  output logic [3:0]  note_value,
  output logic [25:0] duration_value,
  output logic [1:0]  song_index,
  output logic        end_of_song,
  output logic        song_restart
);

  localparam logic [25:0] c_eighth  = 26'd12_500_000;
  localparam logic [25:0] c_quarter = 26'd25_000_000;
  localparam logic [25:0] c_half    = 26'd50_000_000;

  // ROM word = {note[3:0], duration[25:0]}; duration 0 marks end of song.
  // Unlisted entries of songs 0-2 default to markers. Song 3 is a ramp:
  // note = k mod 8, duration = (k+1) * 1_000_000 for k < 20.
  function automatic logic [29:0] rom_word(input logic [6:0] addr);
    logic [29:0] word;
    logic [25:0] ramp;
    word = '0;
    ramp = (26'(addr[4:0]) + 26'd1) * 26'd1_000_000;
    if (addr[6:5] == 2'd3) begin
      if (addr[4:0] < 5'd20) word = {1'b0, addr[2:0], ramp};
    end else begin
      case (addr)
        // song 0
        7'd0:    word = {4'd1,  c_quarter};
        7'd1:    word = {4'd1,  c_quarter};
        7'd2:    word = {4'd5,  c_quarter};
        7'd3:    word = {4'd5,  c_quarter};
        7'd4:    word = {4'd6,  c_quarter};
        7'd5:    word = {4'd6,  c_quarter};
        7'd6:    word = {4'd5,  c_half};
        7'd7:    word = {4'd0,  c_quarter};
        // song 1 (entry 3 carries note 15, played as a rest)
        7'd32:   word = {4'd3,  c_eighth};
        7'd33:   word = {4'd4,  c_eighth};
        7'd34:   word = {4'd5,  c_quarter};
        7'd35:   word = {4'd15, c_eighth};
        7'd36:   word = {4'd5,  c_eighth};
        7'd37:   word = {4'd4,  c_quarter};
        7'd38:   word = {4'd3,  c_quarter};
        7'd39:   word = {4'd2,  c_half};
        7'd40:   word = {4'd1,  c_quarter};
        7'd41:   word = {4'd1,  c_half};
        // song 2
        7'd64:   word = {4'd8,  c_quarter};
        7'd65:   word = {4'd10, c_quarter};
        7'd66:   word = {4'd12, c_quarter};
        7'd67:   word = {4'd14, c_half};
        7'd68:   word = {4'd13, c_eighth};
        7'd69:   word = {4'd12, c_eighth};
        7'd70:   word = {4'd10, c_quarter};
        7'd71:   word = {4'd8,  c_quarter};
        7'd72:   word = {4'd9,  c_quarter};
        7'd73:   word = {4'd11, c_quarter};
        7'd74:   word = {4'd8,  c_half};
        7'd75:   word = {4'd7,  c_half};
        default: word = '0;
      endcase
    end
    return word;
  endfunction

  logic        r_armed;
  logic        r_next_q;
  logic        r_next_d;
  logic        r_prev_q;
  logic        r_prev_d;
  logic [29:0] w_rom;
  logic        w_marker;
  logic        w_next_rise;
  logic        w_prev_rise;
  logic        w_step_up;
  logic        w_step_down;

  assign w_rom       = rom_word({song_index, memory_location});
  assign w_marker    = (w_rom[25:0] == 26'd0);
  assign w_next_rise = r_next_q & ~r_next_d;
  assign w_prev_rise = r_prev_q & ~r_prev_d;
  // Opposing edges in the same cycle cancel out.
  assign w_step_up   = w_next_rise & ~w_prev_rise;
  assign w_step_down = w_prev_rise & ~w_next_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed        <= 1'b0;
      r_next_q       <= 1'b0;
      r_next_d       <= 1'b0;
      r_prev_q       <= 1'b0;
      r_prev_d       <= 1'b0;
      song_index     <= 2'd0;
      note_value     <= 4'd0;
      duration_value <= 26'd0;
      end_of_song    <= 1'b0;
      song_restart   <= 1'b0;
    end else begin
      r_armed  <= 1'b1;
      r_next_q <= song_next;
      r_prev_q <= song_prev;
      // On the first edge after reset the history is seeded with the live
      // level, so a button held through reset is not seen as a new press.
      r_next_d <= r_armed ? r_next_q : song_next;
      r_prev_d <= r_armed ? r_prev_q : song_prev;

      if (w_step_up) begin
        song_index <= song_index + 2'd1;
      end else if (w_step_down) begin
        song_index <= song_index - 2'd1;
      end

      if (w_marker) begin
        note_value     <= 4'd0;
        duration_value <= GAP_CYCLES;
        end_of_song    <= 1'b1;
      end else begin
        note_value     <= (w_rom[29:26] == 4'd15) ? 4'd0 : w_rom[29:26];
        duration_value <= w_rom[25:0];
        end_of_song    <= 1'b0;
      end

      // Song change and end-of-song rising edge share a single pulse.
      song_restart <= w_step_up | w_step_down | (w_marker & ~end_of_song);
    end
  end

endmodule
`default_nettype wire

// File: doc/song_library.md
# song_library

Upstream feeder for `auto_mode`. It holds four fixed songs of up to 32 entries each. Given the `nxt_auto_memory_location` produced by `auto_mode`, it returns the registered note and duration for that entry of the selected song. It also handles song selection from next/prev button levels, detects end-of-song markers, and raises a restart pulse that the top level uses to rewind `auto_mode` to entry 0.

## Interface

Parameters:
- `GAP_CYCLES`, default 26'd25_000_000: rest duration in clk cycles (0.25 s at 100 MHz) output while sitting on an end marker.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; one clock; asynchronous, active-low.
- `memory_location`  in  5  entry index, driven by `auto_mode.nxt_auto_memory_location`.
- `song_next`  in  1  debounced button level; rising edge selects the next song.
- `song_prev`  in  1  debounced button level; rising edge selects the previous song.
- `note_value`  out  4  registered note: 0 = rest, 1–14 = pitch.
- `duration_value`  out  26  registered duration in clk cycles.
- `song_index`  out  2  currently selected song.
- `end_of_song`  out  1  high while the fetched entry is an end marker.
- `song_restart`  out  1  one-cycle pulse; top level drives `auto_mode` `rst` low for that cycle.

## Operation

- ROM entry format: {note[3:0], duration[25:0]}. Address is {song_index, memory_location}, 128 entries total.
- Any entry with duration == 0 is an end marker. Songs 0–2 are team melodies, each terminated by a marker at or before entry 31.
- Song 3 is the test pattern:
  - For k = 0..19: note = k mod 8, duration = (k+1)·1_000_000.
  - Entry 20: end marker.
  - Entries 21–31: end markers.
- Normal fetch, every cycle, when the entry is not a marker:
  - `note_value` ← ROM note; a note of 15 is output as 0.
  - `duration_value` ← ROM duration.
  - `end_of_song` ← 0.
- Marker fetch:
  - `note_value` ← 0, `duration_value` ← `GAP_CYCLES`, `end_of_song` ← 1.
  - `song_restart` pulses once, on the rising edge of `end_of_song` only. A held marker does not retrigger.
- Song select:
  - Each button input is registered once, and the previous sample is kept for edge detection.
  - Rising edge of `song_next`: `song_index` + 1 mod 4 (3 → 0).
  - Rising edge of `song_prev`: `song_index` − 1 mod 4 (0 → 3).
  - Both rising in the same cycle: no change, no pulse.
  - Any index change pulses `song_restart` for one cycle.
- Simultaneous index change and end-of-song rising edge: a single one-cycle pulse only.
- Location 31 of a song with no marker: no special handling. `auto_mode` wraps to 0 on its own.
- Reset (asynchronous, at any time, including mid-song or mid-pulse) forces:
  - `song_index` = 0, `note_value` = 0, `duration_value` = 0.
  - `end_of_song` = 0, `song_restart` = 0.
  - Edge-detect history = 0, so a button held through reset does not count as an edge after release of reset.

## Timing

- Fetch latency: `memory_location` or `song_index` valid at edge N gives outputs at edge N+1. Outputs are fully registered with no combinational path from input to output.
- Button timing, with the level sampled high at edge N after being low at N−1:
  - `song_index` and `song_restart` change at edge N+1.
  - Data from the new song appears at edge N+2.
- `song_restart` rises in the same cycle as `end_of_song`, and is low from the next edge onward.
- Reset deassertion: the first fetch registers at the first clk edge after `rst` goes high.

## Test plan

- Reset behaviour:
  - Stimulus: assert `rst`=0 mid-run with `song_index`=2.
  - Required: all outputs 0 immediately (asynchronous); after release, `song_index`=0 and the entry-0 fetch appears one edge later.
- Normal fetch and latency:
  - Stimulus: song 3 selected, `memory_location`=5.
  - Required: next edge `note_value`=5, `duration_value`=6_000_000, `end_of_song`=0.
- End-of-song:
  - Stimulus: song 3, hold `memory_location`=20 for 10 cycles.
  - Required: `note_value`=0, `duration_value`=25_000_000, `end_of_song`=1 for all 10 cycles, `song_restart` high exactly one cycle.
- Song select wrap:
  - Stimulus: from `song_index`=3, pulse `song_next`.
  - Required: index 0 two edges after the button goes high; `song_restart` is one cycle wide.
  - Stimulus: from index 0, pulse `song_prev`.
  - Required: index 3.
- Simultaneous buttons and held button:
  - Stimulus: `song_next` and `song_prev` rise in the same cycle.
  - Required: no index change, no pulse.
  - Stimulus: hold `song_next` high for 100 cycles.
  - Required: exactly one increment.
- Collision:
  - Stimulus: `song_next` edge lands in the same cycle as the end-marker fetch.
  - Required: a single `song_restart` pulse, and the new index is applied.
